// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
// Shared definitions for the memory port arbiter.
// Contents:
//   state_t          - arbiter FSM encoding (IDLE, READ, WRITE, DONE)
//   SZ_B/SZ_H/SZ_W   - access size codes, stored as bytes-1
//   IO_BASE_DEFAULT  - lowest byte address treated as I/O
//   norm_size()      - maps the unused code 2 onto a word access
//   extend_load()    - sign- or zero-extends an assembled load value
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd3;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;

  // Code 2 has no natural access width, so it is treated as a full word.
  function automatic logic [1:0] norm_size(input logic [1:0] code);
    return (code == 2'd2) ? SZ_W : code;
  endfunction

  // The top captured byte supplies the sign bit for signed loads.
  function automatic logic [31:0] extend_load(input logic [31:0] raw,
                                              input logic [1:0]  code,
                                              input logic        sign_ext);
    logic [31:0] res;
    case (code)
      SZ_B:    res = {{24{sign_ext & raw[7]}}, raw[7:0]};
      SZ_H:    res = {{16{sign_ext & raw[15]}}, raw[15:0]};
      default: res = raw;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/rr_select.sv
// rr_select
// Combinational round-robin selector: picks the lowest-index requester at
// or after ptr, wrapping from NPORT-1 back to 0.
// Ports:
//   req   [NPORT-1:0] in  - request vector
//   ptr   [PW-1:0]    in  - highest-priority port this cycle (< NPORT)
//   grant [NPORT-1:0] out - one-hot grant, all zero when nobody requests
//   index [PW-1:0]    out - index of the granted port (0 when no grant)
module rr_select #(
  parameter int NPORT = 3,
  parameter int PW    = (NPORT > 1) ? $clog2(NPORT) : 1
) (
  input  logic [NPORT-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [NPORT-1:0] grant,
  output logic [PW-1:0]    index
);

  localparam int CW = PW + 1;

  logic [CW-1:0] cand;
  logic          found;

  // Walk the ports starting at ptr; one extra bit on the candidate index
  // lets the wrap be done with a single compare-and-subtract, which also
  // works when NPORT is not a power of two.
  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < NPORT; i++) begin
      cand = {1'b0, ptr} + CW'(i);
      if (cand >= CW'(NPORT)) cand = cand - CW'(NPORT);
      if (!found && req[cand[PW-1:0]]) begin
        found = 1'b1;
        index = cand[PW-1:0];
      end
    end
    if (found) grant[index] = 1'b1;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Serialises 8/16/32-bit loads and stores from NPORT requesters onto a
// byte-wide RAM port, one transaction at a time, round-robin fair.
// Ports:
//   clk, rst (async, active-high), rdy (global enable; freezes all state)
//   mem_din / mem_dout / mem_a / mem_wr - byte RAM port (read data one
//     cycle after its address)
//   io_buffer_full - stalls store beats addressed at or above IO_BASE
//   req/we/sign [NPORT], size [2*NPORT], addr/wdata [32*NPORT] - requests
//   done [NPORT] - completion pulse, rdata - last load result
//   busy - high whenever a transaction is in flight
//   flush - aborts an in-flight load and blocks grants while asserted
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int          NPORT   = 3,
  parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic [7:0]           mem_din,
  output logic [7:0]           mem_dout,
  output logic [31:0]          mem_a,
  output logic                 mem_wr,
  input  logic                 io_buffer_full,
  input  logic [NPORT-1:0]     req,
  input  logic [NPORT-1:0]     we,
  input  logic [NPORT-1:0]     sign,
  input  logic [2*NPORT-1:0]   size,
  input  logic [32*NPORT-1:0]  addr,
  input  logic [32*NPORT-1:0]  wdata,
  output logic [NPORT-1:0]     done,
  output logic [31:0]          rdata,
  output logic                 busy,
  input  logic                 flush
);

  localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;

  state_t         state_q, state_d;
  logic [2:0]     beat_q, beat_d;
  logic [PW-1:0]  ptr_q;
  logic [PW-1:0]  port_q;
  logic           sign_q;
  logic [1:0]     size_q;
  logic [31:0]    addr_q;
  logic [31:0]    wdata_q;
  logic [23:0]    rbuf_q;
  logic [31:0]    rdata_q;

  logic [NPORT-1:0] grant;
  logic [PW-1:0]    gidx;
  logic [31:0]      cur_addr;
  logic             io_stall;
  logic             take;
  logic             cap;
  logic             finish_load;
  logic [31:0]      load_raw;

  rr_select #(
    .NPORT (NPORT),
    .PW    (PW)
  ) u_rr_select (
    .req   (req),
    .ptr   (ptr_q),
    .grant (grant),
    .index (gidx)
  );

  // Address arithmetic wraps naturally at 32 bits.
  assign cur_addr = addr_q + 32'(beat_q);
  assign io_stall = io_buffer_full && (cur_addr >= IO_BASE);

  // The final beat's byte comes straight from mem_din so the load result
  // can be registered on the same edge that moves the FSM to DONE.
  always_comb begin
    load_raw = {8'h00, rbuf_q};
    load_raw[{size_q, 3'b000} +: 8] = mem_din;
  end

  // Next-state and output decode. A read beat k presents addr+k and
  // captures the byte addressed in beat k-1; one extra beat collects the
  // last byte. Write beats only advance when the beat is actually issued.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    take        = 1'b0;
    cap         = 1'b0;
    finish_load = 1'b0;
    mem_a       = '0;
    mem_dout    = '0;
    mem_wr      = 1'b0;
    done        = '0;
    case (state_q)
      ST_IDLE: begin
        if (!flush && (|grant)) begin
          take    = 1'b1;
          beat_d  = '0;
          state_d = (|(we & grant)) ? ST_WRITE : ST_READ;
        end
      end
      ST_READ: begin
        mem_a = cur_addr;
        if (flush) begin
          state_d = ST_IDLE;
          beat_d  = '0;
        end else if (beat_q == ({1'b0, size_q} + 3'd1)) begin
          finish_load = 1'b1;
          state_d     = ST_DONE;
          beat_d      = '0;
        end else begin
          cap    = (beat_q != 3'd0);
          beat_d = beat_q + 3'd1;
        end
      end
      ST_WRITE: begin
        mem_a    = cur_addr;
        mem_dout = wdata_q[{beat_q[1:0], 3'b000} +: 8];
        if (!io_stall) begin
          mem_wr = rdy;
          if (beat_q == {1'b0, size_q}) begin
            state_d = ST_DONE;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + 3'd1;
          end
        end
      end
      ST_DONE: begin
        done[port_q] = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; nothing moves while rdy is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      ptr_q   <= '0;
      port_q  <= '0;
      sign_q  <= 1'b0;
      size_q  <= SZ_B;
      addr_q  <= '0;
      wdata_q <= '0;
      rbuf_q  <= '0;
      rdata_q <= '0;
    end else if (rdy) begin
      state_q <= state_d;
      beat_q  <= beat_d;
      if (take) begin
        ptr_q   <= (gidx == PW'(NPORT - 1)) ? '0 : gidx + PW'(1);
        port_q  <= gidx;
        sign_q  <= sign[gidx];
        size_q  <= norm_size(size[2*gidx +: 2]);
        addr_q  <= addr[32*gidx +: 32];
        wdata_q <= wdata[32*gidx +: 32];
      end
      if (cap) rbuf_q[{beat_q[1:0] - 2'd1, 3'b000} +: 8] <= mem_din;
      if (finish_load) rdata_q <= extend_load(load_raw, size_q, sign_q);
    end
  end

  assign rdata = rdata_q;
  assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed self-checking bench for mem_port_arbiter with a 1 KiB byte RAM
// model (mem[i] = i[7:0], except 0x100..0x103 = 11 22 33 44). Stores are
// logged, not written back, so read contents never change.
// Latency is counted from the first busy cycle of a transaction.
module tb_mem_port_arbiter;

  localparam int NPORT = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic                rdy;
  logic [7:0]          mem_din;
  logic [7:0]          mem_dout;
  logic [31:0]         mem_a;
  logic                mem_wr;
  logic                io_buffer_full;
  logic [NPORT-1:0]    req;
  logic [NPORT-1:0]    we;
  logic [NPORT-1:0]    sign;
  logic [2*NPORT-1:0]  size;
  logic [32*NPORT-1:0] addr;
  logic [32*NPORT-1:0] wdata;
  logic [NPORT-1:0]    done;
  logic [31:0]         rdata;
  logic                busy;
  logic                flush;

  logic [7:0]  mem [1024];
  logic [31:0] wr_a [64];
  logic [7:0]  wr_d [64];
  int          wr_n = 0;

  int tests = 0;
  int fails = 0;

  mem_port_arbiter #(.NPORT(NPORT)) dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .io_buffer_full (io_buffer_full),
    .req            (req),
    .we             (we),
    .sign           (sign),
    .size           (size),
    .addr           (addr),
    .wdata          (wdata),
    .done           (done),
    .rdata          (rdata),
    .busy           (busy),
    .flush          (flush)
  );

  always #5 clk = ~clk;

  // RAM contents
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = i[7:0];
    mem[256] = 8'h11;
    mem[257] = 8'h22;
    mem[258] = 8'h33;
    mem[259] = 8'h44;
  end

  // Synchronous byte RAM: read data follows its address by one cycle;
  // issued write beats are logged in order.
  always @(posedge clk) begin
    mem_din <= mem[mem_a[9:0]];
    if (mem_wr) begin
      if (wr_n < 64) begin
        wr_a[wr_n] = mem_a;
        wr_d[wr_n] = mem_dout;
      end
      wr_n = wr_n + 1;
    end
  end

  // Single comparison point for the whole bench
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Present one request on port p (inputs change only just after a negedge)
  task automatic applyStimulus(input int p, input logic w, input logic s, input logic [1:0] sz,
                               input logic [31:0] a, input logic [31:0] d);
    we[p]             = w;
    sign[p]           = s;
    size[2*p +: 2]    = sz;
    addr[32*p +: 32]  = a;
    wdata[32*p +: 32] = d;
    req[p]            = 1'b1;
  endtask

  // Wait (bounded) for done[p]; drops req[p] on completion like a requester
  task automatic waitDone(input int p, input int maxc, output logic got, output int lat,
                          output logic [31:0] rd);
    int start;
    start = -1;
    got   = 1'b0;
    lat   = -1;
    rd    = '0;
    for (int k = 0; k < maxc; k++) begin
      @(negedge clk);
      if (busy && start < 0) start = k;
      if (done[p]) begin
        got    = 1'b1;
        lat    = k - start;
        rd     = rdata;
        req[p] = 1'b0;
        break;
      end
    end
    if (!got) req[p] = 1'b0;
  endtask

  initial begin
    logic        got;
    int          lat;
    logic [31:0] rd;
    int          base;
    int          start;
    int          n;
    logic        seen;
    int          idx;

    rst = 1'b1; rdy = 1'b1; flush = 1'b0; io_buffer_full = 1'b0;
    req = '0; we = '0; sign = '0; size = '0; addr = '0; wdata = '0;

    // Reset state
    #3;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_mem_wr", mem_wr, 0);
    checkOutput("rst_mem_a", mem_a, 0);
    checkOutput("rst_rdata", rdata, 0);
    checkOutput("rst_mem_dout", mem_dout, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Port 1 LW at 0x100
    base = wr_n;
    applyStimulus(1, 1'b0, 1'b0, 2'd3, 32'h100, 32'h0);
    waitDone(1, 30, got, lat, rd);
    checkOutput("lw_done", got, 1);
    checkOutput("lw_latency", lat, 5);
    checkOutput("lw_rdata", rd, 32'h4433_2211);
    checkOutput("lw_no_write", wr_n - base, 0);
    @(negedge clk);
    checkOutput("lw_done_pulse", done, 0);
    checkOutput("lw_idle", busy, 0);

    // Byte and halfword loads with sign/zero extension
    applyStimulus(0, 1'b0, 1'b1, 2'd0, 32'h80, 32'h0);
    waitDone(0, 30, got, lat, rd);
    checkOutput("lb_s_latency", lat, 2);
    checkOutput("lb_s_rdata", rd, 32'hFFFF_FF80);
    applyStimulus(0, 1'b0, 1'b0, 2'd0, 32'h80, 32'h0);
    waitDone(0, 30, got, lat, rd);
    checkOutput("lbu_rdata", rd, 32'h0000_0080);
    applyStimulus(2, 1'b0, 1'b1, 2'd1, 32'h7F, 32'h0);
    waitDone(2, 30, got, lat, rd);
    checkOutput("lh_s_latency", lat, 3);
    checkOutput("lh_s_rdata", rd, 32'hFFFF_807F);
    applyStimulus(2, 1'b0, 1'b0, 2'd1, 32'h102, 32'h0);
    waitDone(2, 30, got, lat, rd);
    checkOutput("lhu_rdata", rd, 32'h0000_4433);

    // Size code 2 behaves as a word
    applyStimulus(0, 1'b0, 1'b0, 2'd2, 32'h100, 32'h0);
    waitDone(0, 30, got, lat, rd);
    checkOutput("sz2_latency", lat, 5);
    checkOutput("sz2_rdata", rd, 32'h4433_2211);

    // Halfword straddling 0xFFFFFFFF -> 0x00000000 (bytes FF, 00)
    applyStimulus(1, 1'b0, 1'b1, 2'd1, 32'hFFFF_FFFF, 32'h0);
    waitDone(1, 30, got, lat, rd);
    checkOutput("wrap_rdata", rd, 32'h0000_00FF);

    // SB 0x41 to I/O space while the I/O sink is full for 10 cycles
    io_buffer_full = 1'b1;
    base  = wr_n;
    start = -1;
    got   = 1'b0;
    applyStimulus(2, 1'b1, 1'b0, 2'd0, 32'h0003_0000, 32'h0000_0041);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy && start < 0) start = k;
      if (start >= 0) begin
        if (k - start == 5) checkOutput("sb_stall_wr", mem_wr, 0);
        if (k - start == 10) begin
          checkOutput("sb_stall_count", wr_n - base, 0);
          io_buffer_full = 1'b0;
        end
        if (done[2]) begin
          got = 1'b1;
          checkOutput("sb_done_cycle", k - start, 11);
          req[2] = 1'b0;
          break;
        end
      end
    end
    req[2] = 1'b0;
    io_buffer_full = 1'b0;
    checkOutput("sb_done", got, 1);
    checkOutput("sb_writes", wr_n - base, 1);
    checkOutput("sb_wdata", wr_d[base], 8'h41);
    checkOutput("sb_waddr", wr_a[base], 32'h0003_0000);

    // SW below IO_BASE is not stalled by a full I/O sink
    io_buffer_full = 1'b1;
    base = wr_n;
    applyStimulus(0, 1'b1, 1'b0, 2'd3, 32'h200, 32'hDEAD_BEEF);
    waitDone(0, 30, got, lat, rd);
    io_buffer_full = 1'b0;
    checkOutput("sw_latency", lat, 4);
    checkOutput("sw_writes", wr_n - base, 4);
    checkOutput("sw_wdata", {wr_d[base+3], wr_d[base+2], wr_d[base+1], wr_d[base]}, 32'hDEAD_BEEF);
    checkOutput("sw_waddr_first", wr_a[base], 32'h200);
    checkOutput("sw_waddr_last", wr_a[base+3], 32'h203);
    checkOutput("sw_rdata_kept", rdata, 32'h0000_00FF);

    // Flush during beat 2 of a LW
    start = -1;
    seen  = 1'b0;
    applyStimulus(0, 1'b0, 1'b0, 2'd3, 32'h100, 32'h0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy && start < 0) start = k;
      if (done[0]) seen = 1'b1;
      if (start >= 0 && k - start == 2) begin
        flush  = 1'b1;
        req[0] = 1'b0;
      end else if (start >= 0 && k - start == 3) begin
        flush = 1'b0;
        checkOutput("flush_idle", busy, 0);
      end
    end
    flush  = 1'b0;
    req[0] = 1'b0;
    checkOutput("flush_started", (start >= 0), 1);
    checkOutput("flush_no_done", seen, 0);
    checkOutput("flush_rdata_kept", rdata, 32'h0000_00FF);
    applyStimulus(0, 1'b0, 1'b0, 2'd0, 32'h80, 32'h0);
    waitDone(0, 30, got, lat, rd);
    checkOutput("post_flush_done", got, 1);
    checkOutput("post_flush_rdata", rd, 32'h0000_0080);

    // Reset in the middle of a SW
    start = -1;
    applyStimulus(1, 1'b1, 1'b0, 2'd3, 32'h200, 32'hCAFE_F00D);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy && start < 0) start = k;
      if (start >= 0 && k - start == 1) begin
        checkOutput("rstmid_wr_active", mem_wr, 1);
        rst = 1'b1;
        #1;
        checkOutput("rstmid_wr", mem_wr, 0);
        checkOutput("rstmid_busy", busy, 0);
        checkOutput("rstmid_mem_a", mem_a, 0);
        break;
      end
    end
    req = '0;
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (|done) seen = 1'b1;
    end
    checkOutput("rstmid_no_done", seen, 0);

    // rdy low freezes a store and suppresses mem_wr
    base  = wr_n;
    start = -1;
    got   = 1'b0;
    applyStimulus(0, 1'b1, 1'b0, 2'd1, 32'h200, 32'h0000_BBAA);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (busy && start < 0) start = k;
      if (start >= 0) begin
        if (k - start == 0) rdy = 1'b0;
        if (k - start == 2) begin
          checkOutput("frz_wr", mem_wr, 0);
          checkOutput("frz_mem_a", mem_a, 32'h200);
          checkOutput("frz_no_write", wr_n - base, 0);
          rdy = 1'b1;
        end
        if (done[0]) begin
          got = 1'b1;
          req[0] = 1'b0;
          break;
        end
      end
    end
    rdy    = 1'b1;
    req[0] = 1'b0;
    checkOutput("frz_done", got, 1);
    checkOutput("frz_writes", wr_n - base, 2);
    checkOutput("frz_wdata", {wr_d[base+1], wr_d[base]}, 16'hBBAA);
    checkOutput("frz_waddr", wr_a[base+1], 32'h201);

    // Three continuous LW requesters from reset: grants rotate 0,1,2,0,1,2
    @(negedge clk);
    rst = 1'b1;
    for (int p = 0; p < NPORT; p++) applyStimulus(p, 1'b0, 1'b0, 2'd3, 32'h100, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int k = 0; k < 80 && n < 6; k++) begin
      @(negedge clk);
      if (|done) begin
        idx = (done == 3'b001) ? 0 : (done == 3'b010) ? 1 : (done == 3'b100) ? 2 : 9;
        checkOutput($sformatf("rr_order_%0d", n), idx, n % 3);
        checkOutput($sformatf("rr_rdata_%0d", n), rdata, 32'h4433_2211);
        n++;
      end
    end
    req = '0;
    checkOutput("rr_count", n, 6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
